// File: rtl/adc_spi_master.sv
// SPI mode-0 master for the AD9434 3-wire configuration port (SCLK/CSB/SDIO).
// Shifts one 24-bit frame MSB-first; reads turn SDIO around for the trailing byte.

`timescale 1ns / 1ps

module adc_spi_master #(
  parameter int unsigned MOSI_DATA_WIDTH = 24,
  parameter int unsigned MISO_DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_spi_wr_cmd,
  input  logic                       i_spi_rd_cmd,
  input  logic [MOSI_DATA_WIDTH-1:0] i_spi_wr_data,
  output logic [MISO_DATA_WIDTH-1:0] o_spi_rd_data,
  output logic                       o_spi_busy,
  output logic                       o_spi_done,
  output logic                       o_sclk,
  output logic                       o_csb,
  output logic                       o_sdio_o,
  output logic                       o_sdio_oe,
  input  logic                       i_sdio_i
);

  localparam logic [7:0] DivLast    = 8'(CLK_DIV - 1);
  localparam logic [4:0] BitLast    = 5'(MOSI_DATA_WIDTH - 1);
  localparam logic [4:0] BitRdFirst = 5'(MOSI_DATA_WIDTH - MISO_DATA_WIDTH);
  localparam logic [4:0] BitTurn    = 5'(MOSI_DATA_WIDTH - MISO_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftHi,
    StShiftLo,
    StGap
  } state_e;

  state_e                     state_q, state_d;
  logic [7:0]                 div_q, div_d;
  logic [4:0]                 bit_q, bit_d;
  logic [MOSI_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                       is_rd_q, is_rd_d;
  logic [MISO_DATA_WIDTH-1:0] rd_shift_q, rd_shift_d;
  logic [MISO_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [1:0]                 rst_sync_q, rst_sync_d;

  logic div_end;
  logic accept;
  logic frame_done;
  logic csb_active;

  assign div_end    = (div_q == DivLast);
  // Commands are held off until the synchronized reset release completes.
  assign accept     = (state_q == StIdle) && rst_sync_q[1] && (i_spi_wr_cmd || i_spi_rd_cmd);
  assign frame_done = (state_q == StGap) && div_end;
  assign csb_active = (state_q == StSetup) || (state_q == StShiftHi) || (state_q == StShiftLo);

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      is_rd_q    <= 1'b0;
      rd_shift_q <= '0;
      rd_data_q  <= '0;
      rst_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      is_rd_q    <= is_rd_d;
      rd_shift_q <= rd_shift_d;
      rd_data_q  <= rd_data_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StSetup;
      end
      StSetup: begin
        if (div_end) state_d = StShiftHi;
      end
      StShiftHi: begin
        if (div_end) state_d = StShiftLo;
      end
      StShiftLo: begin
        if (div_end) state_d = (bit_q == BitLast) ? StGap : StShiftHi;
      end
      StGap: begin
        if (div_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: divider, bit counter, shift registers.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};

    div_d = div_q + 8'd1;
    if ((state_q == StIdle) || div_end) div_d = '0;

    bit_d = bit_q;
    if (accept) begin
      bit_d = '0;
    end else if ((state_q == StShiftLo) && div_end && (bit_q != BitLast)) begin
      bit_d = bit_q + 5'd1;
    end

    // Shifting at the end of SHIFT_HI makes the next bit appear on SHIFT_LO entry.
    shift_d = shift_q;
    if (accept) begin
      shift_d = i_spi_wr_data;
    end else if ((state_q == StShiftHi) && div_end) begin
      shift_d = {shift_q[MOSI_DATA_WIDTH-2:0], 1'b0};
    end

    is_rd_d = is_rd_q;
    if (accept) is_rd_d = i_spi_rd_cmd;

    rd_shift_d = rd_shift_q;
    if ((state_q == StShiftHi) && (div_q == 8'd0) && is_rd_q && (bit_q >= BitRdFirst)) begin
      rd_shift_d = {rd_shift_q[MISO_DATA_WIDTH-2:0], i_sdio_i};
    end

    rd_data_d = rd_data_q;
    if (frame_done && is_rd_q) rd_data_d = rd_shift_q;
  end

  // Outputs decoded from state so reset forces them idle without waiting for clk.
  always_comb begin
    o_spi_busy = (state_q != StIdle);
    o_spi_done = frame_done;
    o_csb      = !csb_active;
    o_sclk     = (state_q == StShiftHi);
    o_sdio_o   = csb_active ? shift_q[MOSI_DATA_WIDTH-1] : 1'b0;
    o_sdio_oe  = csb_active;
    if (is_rd_q && ((bit_q > BitTurn) || ((bit_q == BitTurn) && (state_q == StShiftLo)))) begin
      o_sdio_oe = 1'b0;
    end
    // Bypass lets the new byte be seen in the done cycle itself.
    o_spi_rd_data = (frame_done && is_rd_q) ? rd_shift_q : rd_data_q;
  end

endmodule

// File: tb/tb_adc_spi_master.sv
// Scoreboard bench for adc_spi_master: a slave model captures each frame and a
// monitor checks it against queued expectations on every done pulse.

`timescale 1ns / 1ps

module tb_adc_spi_master;

  localparam int unsigned Div         = 4;
  localparam int unsigned FrameCycles = 50 * Div;
  localparam int unsigned CsbLowCyc   = 49 * Div;

  typedef struct packed {
    logic [23:0] mosi;
    logic        rd;
    logic [7:0]  rd_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_cmd = 1'b0;
  logic        rd_cmd = 1'b0;
  logic [23:0] wr_data = '0;
  logic [7:0]  rd_data;
  logic        busy, done, sclk, csb, sdio_o, sdio_oe;
  logic        sdio_i = 1'b0;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  logic [7:0] slave_byte = '0;

  // Monitor / slave state
  int          edge_n = 0;
  int          busy_cnt = 0;
  int          csb_lo_cnt = 0;
  int          csb_hi_cnt = 0;
  logic [23:0] mosi_cap = '0;
  logic [23:0] oe_edges = '0;
  logic        oe_all = 1'b1;
  logic        frame_seen = 1'b0;
  logic        sclk_prev = 1'b0, csb_prev = 1'b1, busy_prev = 1'b0;

  always #5 clk = ~clk;

  adc_spi_master #(
    .MOSI_DATA_WIDTH(24),
    .MISO_DATA_WIDTH(8),
    .CLK_DIV        (Div)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_spi_wr_cmd (wr_cmd),
    .i_spi_rd_cmd (rd_cmd),
    .i_spi_wr_data(wr_data),
    .o_spi_rd_data(rd_data),
    .o_spi_busy   (busy),
    .o_spi_done   (done),
    .o_sclk       (sclk),
    .o_csb        (csb),
    .o_sdio_o     (sdio_o),
    .o_sdio_oe    (sdio_oe),
    .i_sdio_i     (sdio_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL timeout_%s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic send(input logic wr, input logic rd, input logic [23:0] data);
    @(negedge clk);
    wr_cmd  = wr;
    rd_cmd  = rd;
    wr_data = data;
    @(negedge clk);
    wr_cmd = 1'b0;
    rd_cmd = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * FrameCycles; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  // Slave model and scoreboard monitor, sampled on the falling clk edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        edge_n     = 0;
        busy_cnt   = 0;
        csb_lo_cnt = 0;
        csb_hi_cnt = 0;
        frame_seen = 1'b0;
        sdio_i     = 1'b0;
        sclk_prev  = 1'b0;
        csb_prev   = 1'b1;
        busy_prev  = 1'b0;
      end else begin
        if (csb_prev && !csb) begin
          if (frame_seen) check("csb_gap_min", 32'(csb_hi_cnt >= int'(Div)), 32'd1);
          edge_n     = 0;
          csb_lo_cnt = 0;
          csb_hi_cnt = 0;
          mosi_cap   = '0;
          oe_edges   = '0;
          oe_all     = 1'b1;
          frame_seen = 1'b1;
        end
        if (csb) begin
          csb_hi_cnt++;
        end else begin
          csb_lo_cnt++;
          if (!sdio_oe) oe_all = 1'b0;
        end
        if (!busy_prev && busy) busy_cnt = 0;
        if (busy) busy_cnt++;
        if (!sclk_prev && sclk) begin
          if (edge_n < 24) begin
            mosi_cap         = {mosi_cap[22:0], sdio_o};
            oe_edges[edge_n] = sdio_oe;
          end
          edge_n++;
        end
        if (sclk_prev && !sclk && edge_n >= 16 && edge_n < 24) begin
          sdio_i = slave_byte[7 - (edge_n - 16)];
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done pulse, want none (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            done_cnt++;
            check("mosi_frame", 32'(mosi_cap), 32'(e.mosi));
            check("sclk_edges", 32'(edge_n), 32'd24);
            check("busy_cycles", 32'(busy_cnt), 32'(FrameCycles));
            check("csb_low_cycles", 32'(csb_lo_cnt), 32'(CsbLowCyc));
            check("oe_at_edges", 32'(oe_edges), e.rd ? 32'h00FFFF : 32'hFFFFFF);
            check("oe_all_csb_low", 32'(oe_all), e.rd ? 32'd0 : 32'd1);
            check("rd_data", 32'(rd_data), 32'(e.rd_data));
          end
        end
        sclk_prev = sclk;
        csb_prev  = csb;
        busy_prev = busy;
      end
    end
  end

  initial begin
    logic ok;
    #1;
    check("rst_csb", 32'(csb), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_sdio_o", 32'(sdio_o), 32'd0);
    check("rst_sdio_oe", 32'(sdio_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Plain write
    exp_q.push_back('{mosi: 24'h001418, rd: 1'b0, rd_data: 8'h00});
    send(1'b1, 1'b0, 24'h001418);
    wait_idle("write");

    // Read
    slave_byte = 8'h6A;
    exp_q.push_back('{mosi: 24'h008001, rd: 1'b1, rd_data: 8'h6A});
    send(1'b0, 1'b1, 24'h008001);
    wait_idle("read");
    @(negedge clk);
    check("rd_data_held", 32'(rd_data), 32'h6A);

    // Both commands: read wins
    slave_byte = 8'h03;
    exp_q.push_back('{mosi: 24'h00802A, rd: 1'b1, rd_data: 8'h03});
    send(1'b1, 1'b1, 24'h00802A);
    wait_idle("both");

    // Command while busy is ignored
    exp_q.push_back('{mosi: 24'h00550F, rd: 1'b0, rd_data: 8'h03});
    send(1'b1, 1'b0, 24'h00550F);
    repeat (48) @(negedge clk);
    send(1'b1, 1'b0, 24'hFFFFFF);
    wait_idle("busy_cmd");
    repeat (5) @(negedge clk);

    // Back-to-back with held write request
    exp_q.push_back('{mosi: 24'h000F08, rd: 1'b0, rd_data: 8'h03});
    exp_q.push_back('{mosi: 24'h00FF01, rd: 1'b0, rd_data: 8'h03});
    @(negedge clk);
    wr_cmd  = 1'b1;
    wr_data = 24'h000F08;
    @(negedge clk);
    check("b2b_first_busy", 32'(busy), 32'd1);
    wr_data = 24'h00FF01;
    ok = 1'b0;
    for (int i = 0; i < 2 * FrameCycles; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("b2b_done");
    @(negedge clk);
    check("b2b_idle_one_cycle", 32'(busy), 32'd0);
    @(negedge clk);
    check("b2b_restart", 32'(busy), 32'd1);
    wr_cmd = 1'b0;
    wait_idle("b2b");
    repeat (5) @(negedge clk);

    // Reset in the middle of a read frame
    slave_byte = 8'hC3;
    send(1'b0, 1'b1, 24'h808055);
    ok = 1'b0;
    for (int i = 0; i < 2 * FrameCycles; i++) begin
      @(negedge clk);
      if (edge_n == 11) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("edge_11");
    rst_n = 1'b0;
    #1;
    check("midrst_csb", 32'(csb), 32'd1);
    check("midrst_sclk", 32'(sclk), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sdio_oe", 32'(sdio_oe), 32'd0);
    check("midrst_rd_data", 32'(rd_data), 32'd0);
    repeat (3) @(negedge clk);
    rd_cmd  = 1'b1;
    wr_data = 24'h808055;
    exp_q.push_back('{mosi: 24'h808055, rd: 1'b1, rd_data: 8'hC3});
    rst_n = 1'b1;
    @(negedge clk);
    check("release_edge1_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("release_edge2_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("release_edge3_busy", 32'(busy), 32'd1);
    rd_cmd = 1'b0;
    wait_idle("post_reset_read");

    repeat (20) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'd7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
